// File: rtl/fetch_redirect_ctrl.sv
// Fetch-stage PC owner. Arbitrates SIIC entry, RTI return, N redirect
// channels and halt. A single pending slot holds a redirect that could not
// be applied because of a stall; with REG_REDIRECT=1 every redirect passes
// through that slot, which adds one cycle of latency.
module fetch_redirect_ctrl #(
   parameter int ADDR_W       = 16,
   parameter int NUM_SRC      = 2,
   parameter int REG_REDIRECT = 0,
   parameter int PC_INC       = 2,
   parameter int RESET_PC     = 0,
   parameter int SIIC_VECTOR  = 2
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      stall_i,
   input  logic                      halt_req_i,
   input  logic                      siic_req_i,
   input  logic                      rti_req_i,
   input  logic [NUM_SRC-1:0]        redir_valid_i,
   input  logic [NUM_SRC*ADDR_W-1:0] redir_addr_i,
   output logic [ADDR_W-1:0]         pc_out_o,
   output logic [ADDR_W-1:0]         pc_plus_o,
   output logic                      flush_out_o,
   output logic                      halted_o,
   output logic                      in_exc_o,
   output logic [ADDR_W-1:0]         epc_out_o
);

   localparam logic [ADDR_W-1:0] RESET_PC_C = ADDR_W'(RESET_PC);
   localparam logic [ADDR_W-1:0] SIIC_VEC_C = ADDR_W'(SIIC_VECTOR);
   localparam logic [ADDR_W-1:0] PC_INC_C   = ADDR_W'(PC_INC);

   typedef enum logic {ST_RUN, ST_HALT} state_t;
   typedef enum logic [1:0] {REQ_CHAN, REQ_SIIC, REQ_RTI} req_kind_t;

   state_t            state_q;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] epc_q;
   logic              in_exc_q;
   logic              flush_q;
   logic              pend_valid_q;
   req_kind_t         pend_kind_q;
   logic [ADDR_W-1:0] pend_addr_q;

   logic [ADDR_W-1:0] pc_plus;
   logic              chan_any;
   logic [ADDR_W-1:0] chan_addr;
   logic              sel_valid;
   req_kind_t         sel_kind;
   logic [ADDR_W-1:0] sel_addr;
   logic              apply;
   req_kind_t         act_kind;
   logic [ADDR_W-1:0] act_addr;
   logic              pend_valid_d;
   req_kind_t         pend_kind_d;
   logic [ADDR_W-1:0] pend_addr_d;

   assign pc_plus     = pc_q + PC_INC_C;
   assign pc_out_o    = pc_q;
   assign pc_plus_o   = pc_plus;
   assign flush_out_o = flush_q;
   assign halted_o    = (state_q == ST_HALT);
   assign in_exc_o    = in_exc_q;
   assign epc_out_o   = epc_q;

   // Later pipeline stages win: scan upward so the highest asserted index is kept.
   always_comb begin
      chan_any  = 1'b0;
      chan_addr = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (redir_valid_i[i]) begin
            chan_any  = 1'b1;
            chan_addr = redir_addr_i[i*ADDR_W +: ADDR_W];
         end
      end
   end

   // Priority select; SIIC/RTI are only eligible in the matching exception state.
   always_comb begin
      sel_valid = 1'b0;
      sel_kind  = REQ_CHAN;
      sel_addr  = '0;
      if (siic_req_i && !in_exc_q) begin
         sel_valid = 1'b1;
         sel_kind  = REQ_SIIC;
      end else if (rti_req_i && in_exc_q) begin
         sel_valid = 1'b1;
         sel_kind  = REQ_RTI;
      end else if (chan_any) begin
         sel_valid = 1'b1;
         sel_addr  = chan_addr;
      end
   end

   if (REG_REDIRECT == 0) begin : g_direct
      // A fresh request supersedes the slot and applies at once unless stalled.
      always_comb begin
         act_kind     = sel_valid ? sel_kind : pend_kind_q;
         act_addr     = sel_valid ? sel_addr : pend_addr_q;
         apply        = (sel_valid | pend_valid_q) & ~stall_i;
         pend_valid_d = (sel_valid | pend_valid_q) & stall_i;
         pend_kind_d  = act_kind;
         pend_addr_d  = act_addr;
      end
   end else begin : g_registered
      // Only the slot content is applied; a new request always lands in the slot.
      always_comb begin
         act_kind     = pend_kind_q;
         act_addr     = pend_addr_q;
         apply        = pend_valid_q & ~stall_i;
         pend_valid_d = sel_valid | (pend_valid_q & stall_i);
         pend_kind_d  = sel_valid ? sel_kind : pend_kind_q;
         pend_addr_d  = sel_valid ? sel_addr : pend_addr_q;
      end
   end

   // RUN/HALT state machine with PC, EPC, exception flag, flush and slot registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= ST_RUN;
         pc_q         <= RESET_PC_C;
         epc_q        <= '0;
         in_exc_q     <= 1'b0;
         flush_q      <= 1'b0;
         pend_valid_q <= 1'b0;
         pend_kind_q  <= REQ_CHAN;
         pend_addr_q  <= '0;
      end else begin
         flush_q <= 1'b0;
         case (state_q)
            ST_RUN: begin
               if (halt_req_i) begin
                  // Halt freezes the PC where it is and drops anything queued.
                  state_q      <= ST_HALT;
                  pend_valid_q <= 1'b0;
               end else begin
                  pend_valid_q <= pend_valid_d;
                  pend_kind_q  <= pend_kind_d;
                  pend_addr_q  <= pend_addr_d;
                  if (apply) begin
                     flush_q <= 1'b1;
                     case (act_kind)
                        REQ_SIIC: begin
                           epc_q    <= pc_plus;
                           pc_q     <= SIIC_VEC_C;
                           in_exc_q <= 1'b1;
                        end
                        REQ_RTI: begin
                           pc_q     <= epc_q;
                           in_exc_q <= 1'b0;
                        end
                        default: pc_q <= act_addr;
                     endcase
                  end else if (!stall_i) begin
                     pc_q <= pc_plus;
                  end
               end
            end
            default: begin
               // HALT is left only through reset.
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Bench for fetch_redirect_ctrl: one direct and one registered-redirect
// instance share stimulus; each is compared every cycle against a
// behavioural model, plus hand-computed values for the directed scenarios.
module tb_fetch_redirect_ctrl;

   localparam int AW = 16;
   localparam int NS = 2;
   localparam logic [1:0] K_NONE = 2'd0, K_CHAN = 2'd1, K_SIIC = 2'd2, K_RTI = 2'd3;

   logic clk = 1'b0;
   logic rst_ni;
   logic stall, halt_req, siic_req, rti_req;
   logic [NS-1:0]    redir_valid;
   logic [NS*AW-1:0] redir_addr;

   logic [AW-1:0] pc0, plus0, epc0, pc1, plus1, epc1;
   logic          fl0, hl0, ie0, fl1, hl1, ie1;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   fetch_redirect_ctrl #(.ADDR_W(AW), .NUM_SRC(NS), .REG_REDIRECT(0), .PC_INC(2),
                         .RESET_PC(0), .SIIC_VECTOR(2)) dut0 (
      .clk_i(clk), .rst_ni(rst_ni), .stall_i(stall), .halt_req_i(halt_req),
      .siic_req_i(siic_req), .rti_req_i(rti_req), .redir_valid_i(redir_valid),
      .redir_addr_i(redir_addr), .pc_out_o(pc0), .pc_plus_o(plus0),
      .flush_out_o(fl0), .halted_o(hl0), .in_exc_o(ie0), .epc_out_o(epc0));

   fetch_redirect_ctrl #(.ADDR_W(AW), .NUM_SRC(NS), .REG_REDIRECT(1), .PC_INC(2),
                         .RESET_PC(0), .SIIC_VECTOR(2)) dut1 (
      .clk_i(clk), .rst_ni(rst_ni), .stall_i(stall), .halt_req_i(halt_req),
      .siic_req_i(siic_req), .rti_req_i(rti_req), .redir_valid_i(redir_valid),
      .redir_addr_i(redir_addr), .pc_out_o(pc1), .pc_plus_o(plus1),
      .flush_out_o(fl1), .halted_o(hl1), .in_exc_o(ie1), .epc_out_o(epc1));

   // Architectural state of the reference model. pk/pa is the waiting
   // request; dk/da is the extra one-cycle delay of the registered mode.
   typedef struct packed {
      logic [15:0] pc;
      logic [15:0] epc;
      logic        in_exc;
      logic        halted;
      logic        flush;
      logic [1:0]  pk;
      logic [15:0] pa;
      logic [1:0]  dk;
      logic [15:0] da;
   } mdl_t;

   mdl_t m0, m1;

   function automatic mdl_t reset_mdl();
      mdl_t r;
      r = '0;
      return r;
   endfunction

   // One clock edge of the reference behaviour, using the current inputs.
   function automatic mdl_t mstep(input mdl_t m, input bit regd);
      mdl_t        n;
      logic [1:0]  nk, ok;
      logic [15:0] na, oa;
      logic        found;
      n = m;
      n.flush = 1'b0;
      if (m.halted) return n;
      if (halt_req) begin
         n.halted = 1'b1;
         n.pk = K_NONE;
         n.dk = K_NONE;
         return n;
      end
      nk = K_NONE;
      na = 16'h0;
      if (siic_req && !m.in_exc) nk = K_SIIC;
      else if (rti_req && m.in_exc) nk = K_RTI;
      else begin
         found = 1'b0;
         for (int i = NS - 1; i >= 0; i--) begin
            if (!found && redir_valid[i]) begin
               found = 1'b1;
               nk = K_CHAN;
               na = redir_addr[i*AW +: AW];
            end
         end
      end
      // Registered mode = direct mode seeing each request one cycle late.
      if (regd) begin
         ok = m.dk; oa = m.da;
         n.dk = nk; n.da = na;
      end else begin
         ok = nk; oa = na;
      end
      if (ok != K_NONE) begin
         n.pk = ok;
         n.pa = oa;
      end
      if (stall) return n;
      n.pc = m.pc + 16'd2;
      case (n.pk)
         K_SIIC: begin n.epc = m.pc + 16'd2; n.pc = 16'h0002; n.in_exc = 1'b1; end
         K_RTI:  begin n.pc = m.epc; n.in_exc = 1'b0; end
         K_CHAN: n.pc = n.pa;
         default: ;
      endcase
      if (n.pk != K_NONE) n.flush = 1'b1;
      n.pk = K_NONE;
      return n;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic cmp_all(input string tag);
      check($sformatf("%s d0.pc", tag),     {16'h0, pc0},   {16'h0, m0.pc});
      check($sformatf("%s d0.plus", tag),   {16'h0, plus0}, {16'h0, m0.pc + 16'd2});
      check($sformatf("%s d0.flush", tag),  {31'h0, fl0},   {31'h0, m0.flush});
      check($sformatf("%s d0.halted", tag), {31'h0, hl0},   {31'h0, m0.halted});
      check($sformatf("%s d0.in_exc", tag), {31'h0, ie0},   {31'h0, m0.in_exc});
      check($sformatf("%s d0.epc", tag),    {16'h0, epc0},  {16'h0, m0.epc});
      check($sformatf("%s d1.pc", tag),     {16'h0, pc1},   {16'h0, m1.pc});
      check($sformatf("%s d1.plus", tag),   {16'h0, plus1}, {16'h0, m1.pc + 16'd2});
      check($sformatf("%s d1.flush", tag),  {31'h0, fl1},   {31'h0, m1.flush});
      check($sformatf("%s d1.halted", tag), {31'h0, hl1},   {31'h0, m1.halted});
      check($sformatf("%s d1.in_exc", tag), {31'h0, ie1},   {31'h0, m1.in_exc});
      check($sformatf("%s d1.epc", tag),    {16'h0, epc1},  {16'h0, m1.epc});
   endtask

   // Advance one clock; caller is at posedge+1, returns at posedge+1.
   task automatic step();
      m0 = mstep(m0, 1'b0);
      m1 = mstep(m1, 1'b1);
      @(posedge clk);
      #1;
      cyc++;
      $display("cyc %0d: stall=%0b halt=%0b siic=%0b rti=%0b rv=%b | pc0=%h fl0=%0b pc1=%h fl1=%0b",
               cyc, stall, halt_req, siic_req, rti_req, redir_valid, pc0, fl0, pc1, fl1);
      cmp_all($sformatf("c%0d", cyc));
   endtask

   task automatic idle_inputs();
      stall = 1'b0; halt_req = 1'b0; siic_req = 1'b0; rti_req = 1'b0;
      redir_valid = '0; redir_addr = '0;
   endtask

   task automatic set_redir(input logic [1:0] v, input logic [15:0] a0, input logic [15:0] a1);
      redir_valid = v;
      redir_addr  = {a1, a0};
   endtask

   // Reset asserted mid-cycle; outputs must clear without a clock edge.
   task automatic async_reset();
      #2 rst_ni = 1'b0;
      #1;
      m0 = reset_mdl();
      m1 = reset_mdl();
      check("arst d0.pc",     {16'h0, pc0},  32'h0);
      check("arst d0.halted", {31'h0, hl0},  32'h0);
      check("arst d0.flush",  {31'h0, fl0},  32'h0);
      check("arst d0.in_exc", {31'h0, ie0},  32'h0);
      check("arst d0.epc",    {16'h0, epc0}, 32'h0);
      check("arst d1.pc",     {16'h0, pc1},  32'h0);
      check("arst d1.halted", {31'h0, hl1},  32'h0);
      check("arst d1.in_exc", {31'h0, ie1},  32'h0);
      idle_inputs();
      #2 rst_ni = 1'b1;
   endtask

   function automatic logic [15:0] pick_addr();
      case ($urandom_range(0, 7))
         0: return 16'hFFFF;
         1: return 16'hFFFE;
         default: return 16'($urandom);
      endcase
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int halt_run;
      idle_inputs();
      rst_ni = 1'b1;
      #1 rst_ni = 1'b0;
      #10 rst_ni = 1'b1;
      #1;
      m0 = reset_mdl();
      m1 = reset_mdl();
      check("rst pc",     {16'h0, pc0}, 32'h0);
      check("rst flush",  {31'h0, fl0}, 32'h0);
      check("rst halted", {31'h0, hl0}, 32'h0);
      check("rst epc",    {16'h0, epc0}, 32'h0);
      check("rst in_exc", {31'h0, ie0}, 32'h0);

      // Free run after reset.
      step(); check("run pc1", {16'h0, pc0}, 32'h2);
      step(); check("run pc2", {16'h0, pc0}, 32'h4);
      step(); check("run pc3", {16'h0, pc0}, 32'h6);
      check("run flush", {31'h0, fl0}, 32'h0);

      // Channel priority: channel 1 beats channel 0.
      set_redir(2'b01, 16'h0010, 16'h0000); step();
      check("prio setup", {16'h0, pc0}, 32'h10);
      set_redir(2'b11, 16'h0100, 16'h0200); step();
      check("prio pc", {16'h0, pc0}, 32'h200);
      check("prio flush", {31'h0, fl0}, 32'h1);
      set_redir(2'b00, 16'h0, 16'h0); step();
      check("prio next", {16'h0, pc0}, 32'h202);
      check("prio flush off", {31'h0, fl0}, 32'h0);

      // Redirect held in the slot across a 3-cycle stall.
      set_redir(2'b10, 16'h0, 16'h0020); step();
      stall = 1'b1; set_redir(2'b01, 16'h0300, 16'h0); step();
      check("stall hold1", {16'h0, pc0}, 32'h20);
      check("stall flush", {31'h0, fl0}, 32'h0);
      set_redir(2'b00, 16'h0, 16'h0); step();
      check("stall hold2", {16'h0, pc0}, 32'h20);
      step();
      check("stall hold3", {16'h0, pc0}, 32'h20);
      stall = 1'b0; step();
      check("stall apply", {16'h0, pc0}, 32'h300);
      check("stall flush on", {31'h0, fl0}, 32'h1);
      step();
      check("stall after", {16'h0, pc0}, 32'h302);

      // SIIC / RTI round trip with ignored duplicates.
      set_redir(2'b01, 16'h0040, 16'h0); step();
      set_redir(2'b00, 16'h0, 16'h0); siic_req = 1'b1; step();
      check("siic pc", {16'h0, pc0}, 32'h2);
      check("siic epc", {16'h0, epc0}, 32'h42);
      check("siic in_exc", {31'h0, ie0}, 32'h1);
      step();
      check("siic2 ignored", {16'h0, pc0}, 32'h4);
      check("siic2 epc", {16'h0, epc0}, 32'h42);
      siic_req = 1'b0; rti_req = 1'b1; step();
      check("rti pc", {16'h0, pc0}, 32'h42);
      check("rti in_exc", {31'h0, ie0}, 32'h0);
      step();
      check("rti2 ignored", {16'h0, pc0}, 32'h44);
      rti_req = 1'b0;

      // All-ones PC wraps.
      set_redir(2'b01, 16'hFFFF, 16'h0); step();
      check("wrap plus", {16'h0, plus0}, 32'h1);
      set_redir(2'b00, 16'h0, 16'h0); step();
      check("wrap pc", {16'h0, pc0}, 32'h1);

      // Registered-mode latency, from a known state.
      async_reset();
      set_redir(2'b01, 16'h0010, 16'h0); step();
      check("reg setup0", {16'h0, pc1}, 32'h2);
      set_redir(2'b00, 16'h0, 16'h0); step();
      check("reg setup1", {16'h0, pc1}, 32'h10);
      set_redir(2'b01, 16'h0500, 16'h0); step();
      check("reg t+1", {16'h0, pc1}, 32'h12);
      check("reg d0 direct", {16'h0, pc0}, 32'h500);
      set_redir(2'b00, 16'h0, 16'h0); step();
      check("reg t+2", {16'h0, pc1}, 32'h500);
      check("reg flush", {31'h0, fl1}, 32'h1);

      // Halt under stall, then frozen despite requests, then async reset.
      set_redir(2'b01, 16'h0060, 16'h0); step();
      set_redir(2'b00, 16'h0, 16'h0); halt_req = 1'b1; stall = 1'b1; step();
      check("halt halted", {31'h0, hl0}, 32'h1);
      check("halt pc", {16'h0, pc0}, 32'h60);
      halt_req = 1'b0; stall = 1'b0; set_redir(2'b11, 16'h0700, 16'h0800); step();
      check("halt frozen", {16'h0, pc0}, 32'h60);
      check("halt no flush", {31'h0, fl0}, 32'h0);
      set_redir(2'b00, 16'h0, 16'h0); siic_req = 1'b1; step();
      check("halt siic ignored", {31'h0, ie0}, 32'h0);
      async_reset();

      // Randomized traffic against the model.
      halt_run = 0;
      for (int k = 0; k < 3000; k++) begin
         stall       = ($urandom_range(0, 99) < 30);
         halt_req    = ($urandom_range(0, 299) == 0);
         siic_req    = ($urandom_range(0, 99) < 6);
         rti_req     = ($urandom_range(0, 99) < 10);
         redir_valid = {($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 15)};
         redir_addr  = {pick_addr(), pick_addr()};
         step();
         if (m0.halted) halt_run++;
         else halt_run = 0;
         if (halt_run > 6 || $urandom_range(0, 499) == 0) begin
            async_reset();
            halt_run = 0;
         end
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
